redmule_tile_sequencer: RTL

- Sequences the GEMM tile loop for the RedMulE engine: walks output-row (M), output-column (N) and reduction (K) tile indices in that nesting order, outer to inner.
- Issues one tile command per valid/ready handshake to the streamer/buffer control path, tagging each command with leftover sizes and first/last-K markers.
- Counts Z-store acknowledgements and bounds the number of in-flight output tiles. Raises done once every output tile is stored.
- Sits between the register-file decode (iters/leftovers) and the scheduler FSM driving the X/W/Y/Z buffers.

---
 rtl/redmule_tile_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/redmule_tile_sequencer.sv
// -----------------------------------------------------------------------------
// redmule_tile_sequencer
//
// Walks the GEMM tile loop of the RedMulE engine in M (outer), N, K (inner)
// order and hands one tile command per valid/ready handshake to the
// streamer/buffer control path. Each command carries its tile indices, the
// number of valid rows/columns/K elements (leftover handling on the last
// tile of each dimension) and first-K / last-K markers. Z-store
// acknowledgements are counted to bound the number of output tiles in flight
// and to detect job completion.
//
// Optional feature (compile-time macro REDMULE_SEQ_PERF_EN):
//   defined   : perf_stall_o counts ISSUE cycles lost to back-pressure or
//               in-flight gating (saturating, cleared on an accepted start).
//   undefined : perf_stall_o is tied to zero.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   clear_i            synchronous soft clear (same effect as reset)
//   start_i            job start pulse (accepted in IDLE only)
//   m/n/k_iters_i      tile counts per dimension (0 is a config error)
//   m/n/k_lftovr_i     size of the last tile per dimension (0 = full)
//   tile_valid_o       tile command valid
//   tile_ready_i       consumer ready
//   tile_m/n/k_o       tile indices
//   tile_rows_o        valid rows (M) in the tile
//   tile_cols_o        valid columns (N) in the tile
//   tile_depth_o       valid K elements in the tile
//   tile_first_k_o     first K step: load Y / init accumulation
//   tile_last_k_o      last K step: store Z after this tile
//   store_ack_i        one pulse per completed Z tile store
//   busy_o             job in progress
//   done_o             single-cycle completion pulse
//   err_o              sticky error (bad config or unexpected store ack)
//   perf_stall_o       stall counter (see macro above)
// -----------------------------------------------------------------------------
module redmule_tile_sequencer #(
    parameter int ARRAY_HEIGHT = 4,
    parameter int PIPE_REGS    = 3,
    parameter int ARRAY_WIDTH  = 12,
    parameter int TOT_DEPTH    = 16,
    parameter int ITER_W       = 16,
    parameter int MAX_OUTST    = 2
) (
    input  logic                                              clk_i,
    input  logic                                              rst_ni,
    input  logic                                              clear_i,
    input  logic                                              start_i,
    input  logic [ITER_W-1:0]                                 m_iters_i,
    input  logic [ITER_W-1:0]                                 n_iters_i,
    input  logic [ITER_W-1:0]                                 k_iters_i,
    input  logic [7:0]                                        m_lftovr_i,
    input  logic [7:0]                                        n_lftovr_i,
    input  logic [7:0]                                        k_lftovr_i,
    output logic                                              tile_valid_o,
    input  logic                                              tile_ready_i,
    output logic [ITER_W-1:0]                                 tile_m_o,
    output logic [ITER_W-1:0]                                 tile_n_o,
    output logic [ITER_W-1:0]                                 tile_k_o,
    output logic [$clog2(ARRAY_WIDTH):0]                      tile_rows_o,
    output logic [$clog2((PIPE_REGS+1)*ARRAY_HEIGHT):0]       tile_cols_o,
    output logic [$clog2(TOT_DEPTH):0]                        tile_depth_o,
    output logic                                              tile_first_k_o,
    output logic                                              tile_last_k_o,
    input  logic                                              store_ack_i,
    output logic                                              busy_o,
    output logic                                              done_o,
    output logic                                              err_o,
    output logic [31:0]                                       perf_stall_o
);

    localparam int N_TILE = (PIPE_REGS + 1) * ARRAY_HEIGHT;
    localparam int ROWS_W = $clog2(ARRAY_WIDTH) + 1;
    localparam int COLS_W = $clog2(N_TILE) + 1;
    localparam int DEP_W  = $clog2(TOT_DEPTH) + 1;
    localparam int OUT_W  = $clog2(MAX_OUTST + 1);
    localparam int ACK_W  = 2 * ITER_W;

    localparam logic [ITER_W-1:0] ONE = ITER_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT_ST = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;

    logic [ITER_W-1:0]   r_m_iters, r_n_iters, r_k_iters;
    logic [7:0]          r_m_lft, r_n_lft, r_k_lft;
    logic [ITER_W-1:0]   r_m, r_n, r_k;
    logic                r_valid;
    logic [OUT_W-1:0]    r_outst;
    logic [ACK_W-1:0]    r_acked;
    logic                r_err;

    logic                w_cfg_zero, w_start_ok, w_start_bad;
    logic                w_hs, w_k_last, w_n_last, w_m_last, w_final;
    logic                w_ack_ok, w_ack_bad, w_inc;
    logic [OUT_W-1:0]    w_outst_nxt;
    logic [ITER_W-1:0]   w_m_nxt, w_n_nxt, w_k_nxt;
    logic                w_gate_nxt;
    logic [ACK_W-1:0]    w_mn;
    logic                w_all_acked;
    logic [ROWS_W-1:0]   w_rows;
    logic [COLS_W-1:0]   w_cols;
    logic [DEP_W-1:0]    w_depth;

    // -------------------------------------------------------------------------
    // Control decode
    // -------------------------------------------------------------------------
    assign w_cfg_zero  = (m_iters_i == '0) || (n_iters_i == '0) || (k_iters_i == '0);
    assign w_start_ok  = (r_state == S_IDLE) && start_i && !w_cfg_zero;
    assign w_start_bad = (r_state == S_IDLE) && start_i &&  w_cfg_zero;

    assign w_hs     = r_valid && tile_ready_i;
    assign w_k_last = (r_k == r_k_iters - ONE);
    assign w_n_last = (r_n == r_n_iters - ONE);
    assign w_m_last = (r_m == r_m_iters - ONE);
    assign w_final  = w_k_last && w_n_last && w_m_last;

    // Acks outside a job are stale leftovers from an aborted job: drop silently.
    assign w_ack_ok  = store_ack_i && (r_state != S_IDLE) && (r_outst != '0);
    assign w_ack_bad = store_ack_i && (r_state != S_IDLE) && (r_outst == '0);
    assign w_inc     = w_hs && w_k_last;

    always_comb begin
        w_outst_nxt = r_outst;
        if (w_inc && !w_ack_ok) begin
            w_outst_nxt = r_outst + OUT_W'(1);
        end else if (!w_inc && w_ack_ok) begin
            w_outst_nxt = r_outst - OUT_W'(1);
        end
    end

    // Index advance: K innermost, then N, then M. The final wrap returns all
    // indices to zero, which is also the idle value.
    always_comb begin
        w_m_nxt = r_m;
        w_n_nxt = r_n;
        w_k_nxt = r_k;
        if (w_hs) begin
            if (w_k_last) begin
                w_k_nxt = '0;
                if (w_n_last) begin
                    w_n_nxt = '0;
                    w_m_nxt = w_m_last ? '0 : r_m + ONE;
                end else begin
                    w_n_nxt = r_n + ONE;
                end
            end else begin
                w_k_nxt = r_k + ONE;
            end
        end
    end

    // Gate for the tile that will be presented next cycle: a new output tile
    // (first K step) may not start while MAX_OUTST tiles await their store.
    assign w_gate_nxt = (w_outst_nxt == OUT_W'(MAX_OUTST)) && (w_k_nxt == '0);

    assign w_mn        = ACK_W'(r_m_iters) * ACK_W'(r_n_iters);
    assign w_all_acked = (r_acked == w_mn);

    assign w_rows  = ((r_m == r_m_iters - ONE) && (r_m_lft != 8'd0)) ?
                     r_m_lft[ROWS_W-1:0] : ROWS_W'(ARRAY_WIDTH);
    assign w_cols  = ((r_n == r_n_iters - ONE) && (r_n_lft != 8'd0)) ?
                     r_n_lft[COLS_W-1:0] : COLS_W'(N_TILE);
    assign w_depth = ((r_k == r_k_iters - ONE) && (r_k_lft != 8'd0)) ?
                     r_k_lft[DEP_W-1:0]  : DEP_W'(TOT_DEPTH);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else if (clear_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_start_ok)       w_state_nxt = S_ISSUE;
            S_ISSUE:   if (w_hs && w_final)  w_state_nxt = S_WAIT_ST;
            S_WAIT_ST: if (w_all_acked)      w_state_nxt = S_DONE;
            S_DONE:                          w_state_nxt = S_IDLE;
            default:                         w_state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (tile attributes read zero whenever no command is offered)
    // -------------------------------------------------------------------------
    always_comb begin
        busy_o         = (r_state == S_ISSUE) || (r_state == S_WAIT_ST);
        done_o         = (r_state == S_DONE);
        tile_valid_o   = r_valid;
        tile_rows_o    = r_valid ? w_rows  : '0;
        tile_cols_o    = r_valid ? w_cols  : '0;
        tile_depth_o   = r_valid ? w_depth : '0;
        tile_first_k_o = r_valid && (r_k == '0);
        tile_last_k_o  = r_valid && w_k_last;
    end

    assign tile_m_o = r_m;
    assign tile_n_o = r_n;
    assign tile_k_o = r_k;
    assign err_o    = r_err;

    // -------------------------------------------------------------------------
    // Datapath / bookkeeping registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_m_iters <= '0;
            r_n_iters <= '0;
            r_k_iters <= '0;
            r_m_lft   <= '0;
            r_n_lft   <= '0;
            r_k_lft   <= '0;
            r_m       <= '0;
            r_n       <= '0;
            r_k       <= '0;
            r_valid   <= 1'b0;
            r_outst   <= '0;
            r_acked   <= '0;
            r_err     <= 1'b0;
        end else if (clear_i) begin
            r_m_iters <= '0;
            r_n_iters <= '0;
            r_k_iters <= '0;
            r_m_lft   <= '0;
            r_n_lft   <= '0;
            r_k_lft   <= '0;
            r_m       <= '0;
            r_n       <= '0;
            r_k       <= '0;
            r_valid   <= 1'b0;
            r_outst   <= '0;
            r_acked   <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_m_iters <= m_iters_i;
                r_n_iters <= n_iters_i;
                r_k_iters <= k_iters_i;
                r_m_lft   <= m_lftovr_i;
                r_n_lft   <= n_lftovr_i;
                r_k_lft   <= k_lftovr_i;
                r_m       <= '0;
                r_n       <= '0;
                r_k       <= '0;
                r_outst   <= '0;
                r_acked   <= '0;
            end else begin
                r_m <= w_m_nxt;
                r_n <= w_n_nxt;
                r_k <= w_k_nxt;
                if (r_state != S_IDLE) begin
                    r_outst <= w_outst_nxt;
                end
                if (w_ack_ok) begin
                    r_acked <= r_acked + ACK_W'(1);
                end
            end

            // Valid is only re-decided when no command is pending: a held
            // command is never withdrawn by the gate.
            case (r_state)
                S_IDLE: r_valid <= w_start_ok;
                S_ISSUE: begin
                    if (r_valid && !tile_ready_i) begin
                        r_valid <= 1'b1;
                    end else if (w_hs && w_final) begin
                        r_valid <= 1'b0;
                    end else begin
                        r_valid <= !w_gate_nxt;
                    end
                end
                default: r_valid <= 1'b0;
            endcase

            if (w_start_ok) begin
                r_err <= 1'b0;
            end else if (w_start_bad || w_ack_bad) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef REDMULE_SEQ_PERF_EN
    // -------------------------------------------------------------------------
    // Stall counter: in ISSUE, valid low can only mean in-flight gating.
    // -------------------------------------------------------------------------
    logic [31:0] r_perf;
    logic        w_stall;

    assign w_stall = (r_state == S_ISSUE) && ((r_valid && !tile_ready_i) || !r_valid);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf <= '0;
        end else if (clear_i) begin
            r_perf <= '0;
        end else if (w_start_ok) begin
            r_perf <= '0;
        end else if (w_stall && (r_perf != '1)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_stall_o = r_perf;
`else
    assign perf_stall_o = '0;
`endif

endmodule
